instr_loader_seq: RTL and testbench

Accelerator-side front end of the CPU peripheral bus. Accepts 32-bit CPU writes, assembles them into 64-bit instructions in an internal instruction store, and on a start command replays the stored program to the compute pipeline over a valid/ready handshake. Raises `cpu_instruction_irq` once the last instruction has been accepted and the pipeline reports idle.

---
 rtl/instr_loader_seq.sv | 135 +++++++++++++
 tb/tb_instr_loader_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader_seq.sv
// rtl/instr_loader_seq.sv - CPU write port that assembles 64-bit instructions and replays them to the pipeline
// Store is not reset; only control state and output registers are.
module instr_loader_seq #(
  parameter int INSTR_NUM_BIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_instruction_valid,
  input  logic [INSTR_NUM_BIT:0]   cpu_instruction_addr,
  input  logic [31:0]              cpu_instruction_data,
  output logic                     cpu_instruction_irq,
  output logic                     busy,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [63:0]              instr_data,
  output logic [INSTR_NUM_BIT-1:0] instr_index,
  input  logic                     exec_idle
);

  localparam int DEPTH = (1 << INSTR_NUM_BIT) - 1;
  localparam logic [INSTR_NUM_BIT-1:0] CMD_IDX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [63:0]              data_q, data_d;
  logic [INSTR_NUM_BIT-1:0] index_q, index_d;
  logic                     busy_q, busy_d;
  logic                     irq_q, irq_d;
  logic [INSTR_NUM_BIT-1:0] cnt_q, cnt_d;
  logic [31:0]              hold_q, hold_d;
  logic [63:0]              mem_q [0:DEPTH-1];

  logic [INSTR_NUM_BIT-1:0] wr_idx;
  logic [INSTR_NUM_BIT-1:0] start_n;
  logic [INSTR_NUM_BIT-1:0] rd_idx;
  logic                     wr_hi, wr_acc, is_cmd, is_start, is_nop_start;
  logic                     mem_we, hold_we, irq_clr;

  assign wr_idx  = cpu_instruction_addr[INSTR_NUM_BIT:1];
  assign wr_hi   = cpu_instruction_addr[0];
  assign start_n = cpu_instruction_data[INSTR_NUM_BIT-1:0];

  // Writes outside IDLE are dropped before they can touch any state.
  assign wr_acc       = cpu_instruction_valid && (state_q == IDLE);
  assign is_cmd       = (wr_idx == CMD_IDX);
  assign is_start     = wr_acc && is_cmd && wr_hi && (start_n != '0);
  assign is_nop_start = wr_acc && is_cmd && wr_hi && (start_n == '0);
  assign mem_we       = wr_acc && !is_cmd && wr_hi;
  assign hold_we      = wr_acc && !is_cmd && !wr_hi;
  assign irq_clr      = wr_acc && !is_nop_start;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    busy_d  = busy_q;
    irq_d   = irq_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    rd_idx  = index_q;
    case (state_q)
      IDLE: begin
        if (hold_we) hold_d = cpu_instruction_data;
        if (irq_clr) irq_d = 1'b0;
        if (is_start) begin
          cnt_d   = start_n;
          index_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // First cycle of ISSUE fetches entry 0; afterwards each acceptance fetches the next.
        if (!valid_q) begin
          data_d  = mem_q[rd_idx];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (instr_ready) begin
          if (index_q == cnt_q - 1'b1) begin
            valid_d = 1'b0;
            state_d = DRAIN;
          end else begin
            rd_idx  = index_q + 1'b1;
            index_d = rd_idx;
            data_d  = mem_q[rd_idx];
          end
        end
      end
      DRAIN: begin
        if (exec_idle) state_d = DONE;
      end
      DONE: begin
        irq_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_idx] <= {cpu_instruction_data, hold_q};
  end

  assign cpu_instruction_irq = irq_q;
  assign busy                = busy_q;
  assign instr_valid         = valid_q;
  assign instr_data          = data_q;
  assign instr_index         = index_q;

endmodule

// File: tb/tb_instr_loader_seq.sv
// tb/tb_instr_loader_seq.sv - scoreboard bench for instr_loader_seq
module tb_instr_loader_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic        irq;
  logic        busy;
  logic        instr_valid;
  logic        instr_ready;
  logic [63:0] instr_data;
  logic [7:0]  instr_index;
  logic        exec_idle;

  int errors = 0;
  int checks = 0;
  logic [71:0] exp_q [$];
  logic [71:0] sb_exp;
  logic [63:0] mdl [0:3];

  always #5 clk = ~clk;

  instr_loader_seq #(.INSTR_NUM_BIT(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .cpu_instruction_valid (cpu_valid),
    .cpu_instruction_addr  (cpu_addr),
    .cpu_instruction_data  (cpu_data),
    .cpu_instruction_irq   (irq),
    .busy                  (busy),
    .instr_valid           (instr_valid),
    .instr_ready           (instr_ready),
    .instr_data            (instr_data),
    .instr_index           (instr_index),
    .exec_idle             (exec_idle)
  );

  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got idx=%0d data=%h, required no instruction", instr_index, instr_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({instr_index, instr_data} !== sb_exp) begin
          errors++;
          $display("FAIL sb_instr: got idx=%0d data=%h, required idx=%0d data=%h",
                   instr_index, instr_data, sb_exp[71:64], sb_exp[63:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    cpu_valid = 1'b1; cpu_addr = a; cpu_data = d;
    @(posedge clk); #2;
    cpu_valid = 1'b0;
  endtask

  task automatic start_run(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({k[7:0], mdl[k]});
    cpu_write(9'h1FF, n);
  endtask

  task automatic wait_irq(input int max_cycles);
    int c;
    for (c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (irq) break;
    end
    checks++;
    if (c == max_cycles) begin
      errors++;
      $display("FAIL irq_timeout: irq=%b after %0d cycles, required 1", irq, max_cycles);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({irq, busy, instr_valid, instr_data, instr_index} !== 75'd0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b busy=%b valid=%b data=%h idx=%0d, required all 0",
               irq, busy, instr_valid, instr_data, instr_index);
    end
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int t0 = -1;
    int t1 = -1;
    cpu_write(9'h000, 32'h11111111);
    cpu_write(9'h001, 32'hAAAAAAAA);
    cpu_write(9'h002, 32'h22222222);
    cpu_write(9'h003, 32'hBBBBBBBB);
    mdl[0] = 64'hAAAAAAAA11111111;
    mdl[1] = 64'hBBBBBBBB22222222;
    instr_ready = 1'b1;
    exec_idle   = 1'b1;
    start_run(2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready && instr_index == 8'd0) t0 = c;
      if (instr_valid && instr_ready && instr_index == 8'd1) begin t1 = c; break; end
    end
    checks++;
    if (t0 != 1 || t1 != 2) begin
      errors++;
      $display("FAIL basic_timing: idx0 at %0d idx1 at %0d, required 1 and 2", t0, t1);
    end
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_drop: valid=%b, required 0", instr_valid);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_irq_early: irq=%b, required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_irq: irq=%b busy=%b, required irq=1 busy=0", irq, busy);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_backpressure;
    int c;
    instr_ready = 1'b0;
    start_run(2);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL bp_irq_clear: irq=%b, required 0", irq);
    end
    for (c = 0; c < 20; c++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_data !== mdl[0] || instr_index !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h idx=%0d, required valid=1 data=%h idx=0",
                 i, instr_valid, instr_data, instr_index, mdl[0]);
      end
    end
    @(posedge clk); #2;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr_index !== 8'd1) begin
      errors++;
      $display("FAIL bp_next: valid=%b idx=%0d, required valid=1 idx=1", instr_valid, instr_index);
    end
    wait_irq(50);
    check_sb_empty("bp");
  endtask

  task automatic test_drain_wait;
    int c;
    instr_ready = 1'b1;
    exec_idle   = 1'b0;
    start_run(2);
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_valid && instr_index == 8'd1) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (irq !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL drain_wait%0d: irq=%b busy=%b, required irq=0 busy=1", i, irq, busy);
      end
    end
    @(posedge clk); #2;
    exec_idle = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_done_cycle: irq=%b busy=%b, required irq=0 busy=1", irq, busy);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_irq: irq=%b busy=%b, required irq=1 busy=0", irq, busy);
    end
    check_sb_empty("drain");
  endtask

  task automatic test_busy_write_drop;
    instr_ready = 1'b1;
    exec_idle   = 1'b1;
    start_run(2);
    cpu_write(9'h001, 32'hDEADBEEF);
    cpu_write(9'h000, 32'h55555555);
    wait_irq(50);
    start_run(2);
    wait_irq(50);
    check_sb_empty("busy_drop");
  endtask

  task automatic test_start_zero;
    cpu_write(9'h1FF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || instr_valid !== 1'b0 || irq !== 1'b1) begin
        errors++;
        $display("FAIL zero_start%0d: busy=%b valid=%b irq=%b, required busy=0 valid=0 irq=1",
                 i, busy, instr_valid, irq);
      end
    end
    cpu_write(9'h004, 32'h12345678);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL zero_irq_clear: irq=%b, required 0", irq);
    end
  endtask

  task automatic test_midrun_reset;
    int c;
    instr_ready = 1'b1;
    exec_idle   = 1'b1;
    start_run(2);
    for (c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_valid && instr_index == 8'd1) break;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: irq=%b busy=%b valid=%b, required all 0", irq, busy, instr_valid);
    end
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    start_run(2);
    wait_irq(50);
    check_sb_empty("midrun");
  endtask

  initial begin
    cpu_valid   = 1'b0;
    cpu_addr    = '0;
    cpu_data    = '0;
    instr_ready = 1'b0;
    exec_idle   = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_drain_wait();
    test_busy_write_drop();
    test_start_zero();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
